// File: rtl/lu_cache_ctrl.sv
// Sequencing controller for a move-to-front lookup cache built from memory_cell instances.
// Each request runs IDLE -> LOOKUP -> UPDATE -> RESP and issues at most one array write strobe.
module lu_cache_ctrl #(
  parameter int CELL_SIZE = 8,
  parameter int ADDR_SIZE = 3,
  parameter int CELL_NUM  = 2**ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [CELL_SIZE-1:0] req_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_hit,
  output logic [ADDR_SIZE-1:0] resp_addr,
  output logic                 resp_evict,
  output logic [CELL_SIZE-1:0] arr_check_data,
  output logic [CELL_SIZE-1:0] arr_front_data,
  output logic [ADDR_SIZE-1:0] arr_input_addr,
  output logic                 arr_wen,
  input  logic [CELL_NUM-1:0]  arr_eq
);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, RESP} state_t;

  localparam logic [ADDR_SIZE:0]   FILL_FULL = (ADDR_SIZE+1)'(CELL_NUM);
  localparam logic [ADDR_SIZE-1:0] LAST_IDX  = ADDR_SIZE'(CELL_NUM-1);

  state_t                 state;
  logic [CELL_SIZE-1:0]   key;
  logic [ADDR_SIZE:0]     fill;
  logic                   hit_q;
  logic                   full_q;
  logic [ADDR_SIZE-1:0]   hit_idx_q;

  logic [CELL_NUM-1:0]    valid_mask;
  logic [CELL_NUM-1:0]    masked_eq;
  logic                   hit_c;
  logic                   full_c;
  logic [ADDR_SIZE-1:0]   hit_idx_c;

  function automatic logic [ADDR_SIZE-1:0] lowest_set(input logic [CELL_NUM-1:0] v);
    lowest_set = '0;
    for (int i = CELL_NUM-1; i >= 0; i--)
      if (v[i]) lowest_set = ADDR_SIZE'(i);
  endfunction

  assign req_ready = (state == IDLE) && !flush;

  // Cells at or beyond the fill level still hold stale or reset contents and must never match.
  always_comb begin
    valid_mask = '0;
    for (int i = 0; i < CELL_NUM; i++)
      valid_mask[i] = ((ADDR_SIZE+1)'(i) < fill);
  end

  assign masked_eq = arr_eq & valid_mask;
  assign hit_c     = |masked_eq;
  assign hit_idx_c = lowest_set(masked_eq);
  assign full_c    = (fill == FILL_FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      key            <= '0;
      fill           <= '0;
      hit_q          <= 1'b0;
      full_q         <= 1'b0;
      hit_idx_q      <= '0;
      resp_valid     <= 1'b0;
      resp_hit       <= 1'b0;
      resp_addr      <= '0;
      resp_evict     <= 1'b0;
      arr_check_data <= '0;
      arr_front_data <= '0;
      arr_input_addr <= '0;
      arr_wen        <= 1'b0;
    end else begin
      case (state)
        // IDLE: flush wins over a pending request
        IDLE: begin
          if (flush) begin
            fill <= '0;
          end else if (req_valid) begin
            key            <= req_data;
            arr_check_data <= req_data;
            state          <= LOOKUP;
          end
        end
        // LOOKUP: arr_eq is sampled only here; the write strobe is prepared for UPDATE
        LOOKUP: begin
          hit_q          <= hit_c;
          hit_idx_q      <= hit_idx_c;
          full_q         <= full_c;
          arr_front_data <= key;
          arr_wen        <= !(hit_c && (hit_idx_c == '0));
          arr_input_addr <= hit_c ? hit_idx_c : (full_c ? LAST_IDX : fill[ADDR_SIZE-1:0]);
          state          <= UPDATE;
        end
        // UPDATE: array shifts on this edge; response is registered alongside
        UPDATE: begin
          arr_wen    <= 1'b0;
          resp_valid <= 1'b1;
          resp_hit   <= hit_q;
          resp_addr  <= hit_q ? hit_idx_q : (full_q ? LAST_IDX : fill[ADDR_SIZE-1:0]);
          resp_evict <= !hit_q && full_q;
          if (!hit_q && !full_q)
            fill <= fill + 1'b1;
          state      <= RESP;
        end
        // RESP: hold payload until the consumer takes it
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lu_cache_ctrl.md
# lu_cache_ctrl

Sequencing controller for the least-used (move-to-front) lookup cache array built from `memory_cell` instances. It accepts key requests over a valid/ready handshake and drives the array's compare bus. It resolves hit/miss from the per-cell `eq` vector, masked by a fill counter. It then issues the single `wen` pulse that performs move-to-front, insert-at-front or evict-last, and returns a hit/miss response.

## Interface
- CELL_SIZE, 8, key/data width per cell
- ADDR_SIZE, 3, cell address width
- CELL_NUM, 2**ADDR_SIZE, number of cells in the array (cell 0 = most recent, CELL_NUM-1 = least recent)

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low
- flush  input  1  logical invalidate of all cells (fill := 0); sampled in IDLE only
- req_valid  input  1  request present
- req_ready  output  1  controller accepts a request this cycle
- req_data  input  CELL_SIZE  key to look up / insert
- resp_valid  output  1  response present, held until accepted
- resp_ready  input  1  consumer accepts response
- resp_hit  output  1  1 = key found, 0 = miss (key inserted)
- resp_addr  output  ADDR_SIZE  hit: position before move-to-front; miss: position of insertion write (fill or CELL_NUM-1)
- resp_evict  output  1  miss with full array: cell CELL_NUM-1 content discarded
- arr_check_data  output  CELL_SIZE  broadcast compare key to all cells
- arr_front_data  output  CELL_SIZE  data into cell 0 (cell i>0 input = cell i-1 output, array wiring)
- arr_input_addr  output  ADDR_SIZE  shift limit: cells with address <= this load on arr_wen
- arr_wen  output  1  one-cycle shift/write strobe
- arr_eq  input  CELL_NUM  per-cell match flags from the array

## Operation
- States: IDLE, LOOKUP, UPDATE, RESP. Reset state IDLE.
- Reset values: all outputs 0, except req_ready. req_ready is combinational, (state==IDLE) && !flush, so it is 1 in reset state. fill counter 0 (width ADDR_SIZE+1). Key register 0.
- IDLE: if flush=1, fill <= 0 and no request is accepted. Else on req_valid && req_ready: key <= req_data, go to LOOKUP.
- LOOKUP: arr_check_data = key. Valid mask: bit i = (i < fill). Hit = |(arr_eq & mask). hit_idx = lowest set index of the masked vector. Latch hit, hit_idx and full = (fill == CELL_NUM). Go to UPDATE.
- UPDATE: arr_front_data = key. arr_check_data stays = key.
  - Hit with hit_idx = 0: no write, arr_wen = 0.
  - Hit with hit_idx > 0: arr_wen = 1, arr_input_addr = hit_idx (move-to-front).
  - Miss, not full: arr_wen = 1, arr_input_addr = fill[ADDR_SIZE-1:0], fill <= fill+1.
  - Miss, full: arr_wen = 1, arr_input_addr = CELL_NUM-1, fill unchanged, evict = 1.
  - Go to RESP; resp_* registered on this edge.
- RESP: resp_valid = 1, payload stable. On resp_ready: resp_valid <= 0, go to IDLE.
- Unmasked arr_eq bits (cells i >= fill, holding reset value 0) never produce a hit. Key 0 on an empty array is a miss.
- flush outside IDLE is ignored (not latched).
- fill saturates at CELL_NUM and never wraps.

## Timing
- Acceptance edge E (IDLE, req_valid=1). LOOKUP is the cycle after E. UPDATE is the cycle after E+1, with arr_wen high for exactly that one cycle. The array updates at E+2, and resp_valid rises at E+2.
- Minimum 4 cycles per request: E, LOOKUP, UPDATE, RESP with resp_ready=1. The next acceptance is possible at E+4 edge.
- resp_ready held low: stay in RESP indefinitely, payload unchanged, req_ready=0.
- req_valid while not IDLE: ignored, req_ready=0. The requester must hold req_valid/req_data until accepted.
- Reset asserted mid-operation: immediate return to IDLE. fill=0, the pending response is dropped, arr_wen=0 while reset is low.
- arr_eq is combinational from the array and sampled only on the LOOKUP→UPDATE edge.

## Test plan
- Reset, then req key 0x00 → miss, resp_addr=0, evict=0, arr_wen one cycle with input_addr=0. Next req 0x00 → hit, resp_addr=0, no arr_wen pulse.
- Insert 0x11, 0x22, 0x33 → three misses with resp_addr 0,1,2. Cell order becomes 0x33,0x22,0x11. Req 0x11 → hit resp_addr=2, arr_input_addr=2. Order becomes 0x11,0x33,0x22.
- Insert 8 distinct keys 0xA0..0xA7, then 0xB0 → miss, evict=1, resp_addr=7, fill stays 8. Req 0xA0 → miss (evicted).
- Hold resp_ready=0 for 5 cycles with req_valid=1 → resp payload stable, req_ready=0, no second arr_wen. Release → IDLE the next cycle.
- flush=1 in IDLE after 4 inserts → req_ready=0 that cycle. A following req for a previously stored key → miss, resp_addr=0.
- Assert reset during UPDATE → arr_wen, resp_valid, fill all 0 immediately. After release, req_ready=1 and the first request is a miss at addr 0.
